// File: rtl/ctech_lib_sync_hs_pkg.sv
// Shared types and constants for the req/ack handshake receiver.
package ctech_lib_sync_hs_pkg;

  typedef enum logic [1:0] {
    HS_IDLE     = 2'd0,
    HS_WAIT_BUF = 2'd1,
    HS_ACK_HI   = 2'd2
  } hs_state_t;

  localparam int ERR_PROTO = 0;
  localparam int ERR_TMO   = 1;

endpackage

// File: rtl/ctech_lib_triplesync.sv
// Three-flop synchronizer for signals arriving asynchronously to clk_i.
module ctech_lib_triplesync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign q_o = s3_q;

endmodule

// File: rtl/ctech_lib_sync_hs_rx.sv
// Destination side of a 4-phase req/ack CDC: syncs req, captures the held data into a
// one-entry buffer, returns ack, and flags protocol violations and stuck-req timeouts.
//
// Handshakes: the source holds data_async stable while req_async is high and only drops req
// after seeing ack; downstream takes o_data on any edge where o_valid && i_ready.
module ctech_lib_sync_hs_rx
  import ctech_lib_sync_hs_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_async,
  input  logic [WIDTH-1:0] data_async,
  output logic             ack,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic [1:0]       err,
  input  logic             err_clr,
  output hs_state_t        dbg_state_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  hs_state_t        state_q;
  logic             ack_q;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       err_q, err_d;
  logic             req_s;
  logic             buf_free;
  logic             capture;
  logic             proto_set;
  logic             tmo_set;

  ctech_lib_triplesync #(.WIDTH(1)) u_req_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (req_async),
    .q_o   (req_s)
  );

  assign buf_free  = !valid_q || i_ready;
  // data_async is only trusted while the synchronized req is high.
  assign capture   = req_s && buf_free &&
                     ((state_q == HS_IDLE) || (state_q == HS_WAIT_BUF));
  assign proto_set = (state_q == HS_WAIT_BUF) && !req_s;
  assign tmo_set   = (TIMEOUT != 0) && (state_q == HS_ACK_HI) && req_s && (cnt_q == CNT_MAX);

  always_comb begin
    err_d = err_clr ? 2'b00 : err_q;
    err_d[ERR_PROTO] = err_d[ERR_PROTO] | proto_set;
    err_d[ERR_TMO]   = err_d[ERR_TMO]   | tmo_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HS_IDLE;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        HS_IDLE: begin
          ack_q <= 1'b0;
          if (req_s) begin
            if (buf_free) begin
              ack_q   <= 1'b1;
              state_q <= HS_ACK_HI;
            end else begin
              state_q <= HS_WAIT_BUF;
            end
          end
        end
        HS_WAIT_BUF: begin
          ack_q <= 1'b0;
          if (!req_s) begin
            state_q <= HS_IDLE;
          end else if (buf_free) begin
            ack_q   <= 1'b1;
            state_q <= HS_ACK_HI;
          end
        end
        HS_ACK_HI: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= HS_IDLE;
          end else if ((TIMEOUT != 0) && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          ack_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= HS_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 2'b00;
    end else begin
      err_q <= err_d;
      if (capture) begin
        valid_q <= 1'b1;
        data_q  <= data_async;
      end else if (valid_q && i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign ack         = ack_q;
  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule
